// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one word-aligned memory read at a time,
// holds the returned word for decode and discards data fetched before a redirect.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned AW = 32;
    localparam int unsigned WW = AW - 2;
    localparam logic [AW-1:0] RESET_PC = {RESET_ADDR[AW-1:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          inst_valid_q, inst_valid_d;
    logic [AW-1:0] inst_data_q, inst_data_d;
    logic [AW-1:0] inst_pc_q, inst_pc_d;
    logic [AW-1:0] redir_pc;
    logic [AW-1:0] pc_next;

    assign redir_pc = {redirect_addr[AW-1:2], 2'b00};
    assign pc_next  = {pc_q[AW-1:2] + WW'(1), 2'b00};

    // Next-state and register updates; a redirect outranks every other event.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;

        if (redirect_valid) begin
            pc_d         = redir_pc;
            inst_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                mem_addr_d = redirect_valid ? redir_pc : pc_q;
                state_d    = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    // An unfinished request must still complete, so drain it in FLUSH.
                    if (mem_ready) begin
                        mem_addr_d = redir_pc;
                    end else begin
                        state_d = FLUSH;
                    end
                end else if (mem_ready) begin
                    inst_data_d  = mem_rdata;
                    inst_pc_d    = mem_addr_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_next;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    mem_addr_d = redir_pc;
                    state_d    = FETCH;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    mem_addr_d   = pc_q;
                    state_d      = FETCH;
                end
            end
            FLUSH: begin
                if (mem_ready) begin
                    mem_addr_d = redirect_valid ? redir_pc : pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            mem_addr_q   <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign mem_req    = (state_q == FETCH) || (state_q == FLUSH);
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: a memory responder checks request
// addresses and a monitor checks every newly presented instruction.
module tb_instr_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 1;
    logic [31:0] exp_req_q[$];
    inst_t       exp_inst_q[$];

    instr_fetch_ctrl #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_inst(input logic [31:0] pc, input logic [31:0] data);
        inst_t it;
        it.pc   = pc;
        it.data = data;
        exp_inst_q.push_back(it);
    endtask

    // Memory model answers after mem_lat cycles; monitor checks each new instruction.
    task automatic responder_and_monitor();
        bit          busy = 0;
        int          cnt = 0;
        logic [31:0] req_addr = '0;
        logic        prev_valid = 1'b0;
        inst_t       it;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!mem_req) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy     = 1;
                    cnt      = mem_lat;
                    req_addr = mem_addr;
                    if (exp_req_q.size() == 0) begin
                        chk("unexpected_request", mem_addr, 32'hxxxx_xxxx);
                    end else begin
                        chk("request_addr", mem_addr, exp_req_q.pop_front());
                    end
                end else begin
                    chk("addr_stable", mem_addr, req_addr);
                end
                if (cnt <= 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = req_addr ^ 32'h2010_000A;
                    busy      = 0;
                end else begin
                    cnt--;
                end
            end
            if (inst_valid && !prev_valid) begin
                if (exp_inst_q.size() == 0) begin
                    chk("unexpected_inst_pc", inst_pc, 32'hxxxx_xxxx);
                end else begin
                    it = exp_inst_q.pop_front();
                    chk("inst_pc", inst_pc, it.pc);
                    chk("inst_data", inst_data, it.data);
                end
            end
            prev_valid = inst_valid;
        end
    endtask

    task automatic wait_valid(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (inst_valid) seen = 1;
        end
        chk("wait_inst_valid", 32'(seen), 32'd1);
    endtask

    task automatic accept_one();
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    initial begin
        fork
            responder_and_monitor();
        join_none

        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0000_0000);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // First fetch from reset address, then hold for five cycles.
        push_req(32'h0000_0000);
        push_inst(32'h0000_0000, 32'h2010_000A);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req_after_release", 32'(mem_req), 32'd1);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_data", inst_data, 32'h2010_000A);
            chk("hold_pc", inst_pc, 32'h0000_0000);
            chk("hold_mem_req", 32'(mem_req), 32'd0);
            @(negedge clk);
        end

        push_req(32'h0000_0004);
        push_inst(32'h0000_0004, 32'h2010_000E);
        accept_one();
        wait_valid(20);

        // Redirect to 0x43 during the first wait cycle of a 3-cycle fetch of 0x8.
        mem_lat = 3;
        push_req(32'h0000_0008);
        accept_one();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0043;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_lat = 1;
        chk("flush_mem_req", 32'(mem_req), 32'd1);
        chk("flush_mem_addr", mem_addr, 32'h0000_0008);
        chk("flush_inst_valid", 32'(inst_valid), 32'd0);
        push_req(32'h0000_0040);
        push_inst(32'h0000_0040, 32'h2010_004A);
        wait_valid(20);

        // Redirect from HOLD to 0xC, then redirect again as 0xC returns.
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_000C;
        push_req(32'h0000_000C);
        @(negedge clk);
        chk("hold_redirect_valid_drop", 32'(inst_valid), 32'd0);
        redirect_addr = 32'h0000_0100;
        push_req(32'h0000_0100);
        push_inst(32'h0000_0100, 32'h2010_010A);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("ready_redirect_valid", 32'(inst_valid), 32'd0);
        chk("ready_redirect_req", 32'(mem_req), 32'd1);
        chk("ready_redirect_addr", mem_addr, 32'h0000_0100);
        wait_valid(20);
        push_req(32'h0000_0104);
        push_inst(32'h0000_0104, 32'h2010_010E);
        accept_one();
        wait_valid(20);

        // Redirect beats inst_ready; top word then wraps to address 0.
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        inst_ready     = 1'b1;
        push_req(32'hFFFF_FFFC);
        push_inst(32'hFFFF_FFFC, 32'hDFEF_FFF6);
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        wait_valid(20);
        push_req(32'h0000_0000);
        push_inst(32'h0000_0000, 32'h2010_000A);
        accept_one();
        wait_valid(20);

        // Asynchronous reset while holding an instruction.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_inst_pc", inst_pc, 32'h0);
        chk("async_rst_inst_data", inst_data, 32'h0);
        chk("async_rst_mem_addr", mem_addr, 32'h0000_0000);
        push_req(32'h0000_0000);
        push_inst(32'h0000_0000, 32'h2010_000A);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("req_after_async_rst", 32'(mem_req), 32'd1);
        wait_valid(20);
        repeat (3) @(negedge clk);

        chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        chk("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_addr as the new fetch address.
REQ-005 The block SHALL have port redirect_addr  input  32  branch/jump target address.
REQ-006 The block SHALL have port mem_req  output  1  instruction-memory read request.
REQ-007 The block SHALL have port mem_addr  output  32  instruction-memory read address.
REQ-008 The block SHALL have port mem_ready  input  1  one-cycle strobe: mem_rdata valid; completes the current request.
REQ-009 The block SHALL have port mem_rdata  input  32  instruction word returned by memory.
REQ-010 The block SHALL have port inst_valid  output  1  inst_data/inst_pc hold a fetched instruction.
REQ-011 The block SHALL have port inst_data  output  32  fetched instruction word.
REQ-012 The block SHALL have port inst_pc  output  32  address the instruction was fetched from.
REQ-013 The block SHALL have port inst_ready  input  1  decode accepts the instruction this cycle.

Function
REQ-014 The block SHALL hold a 32-bit pc register, always word-aligned; pc[1:0] and redirect_addr[1:0] SHALL be forced to 2'b00.
REQ-015 The block SHALL implement states IDLE, FETCH, HOLD, FLUSH; mem_req SHALL be 1 exactly in FETCH and FLUSH, decoded from the state register only.
REQ-016 IDLE: mem_req=0; next edge -> FETCH, with mem_addr<=pc.
REQ-017 FETCH/FLUSH: mem_addr SHALL stay constant until the mem_ready cycle; the memory may take 1 or more cycles.
REQ-018 FETCH with mem_ready=1, redirect_valid=0: inst_data<=mem_rdata, inst_pc<=mem_addr, inst_valid<=1, pc<=pc+4 (modulo 2^32, 0xFFFF_FFFC wraps to 0), -> HOLD.
REQ-019 HOLD: mem_req=0; inst_valid/inst_data/inst_pc SHALL stay stable while inst_ready=0.
REQ-020 HOLD with inst_ready=1: inst_valid<=0, mem_addr<=pc, -> FETCH, so the minimum throughput is one instruction per 2 cycles plus memory latency.
REQ-021 redirect_valid=1 in any state SHALL set pc<=redirect_addr and inst_valid<=0; redirect has priority over every other event in that cycle.
REQ-022 Redirect in HOLD (with or without inst_ready): mem_addr<=redirect_addr, -> FETCH.
REQ-023 Redirect in FETCH with mem_ready=1: mem_rdata SHALL be discarded, mem_addr<=redirect_addr, -> FETCH.
REQ-024 Redirect in FETCH with mem_ready=0: the outstanding request SHALL NOT be aborted; -> FLUSH with mem_addr unchanged.
REQ-025 FLUSH: a further redirect SHALL overwrite pc and stay in FLUSH; on mem_ready, data SHALL be discarded, mem_addr<=pc (or redirect_addr if redirecting that cycle), -> FETCH.
REQ-026 The block SHALL NOT assert inst_valid for any word fetched before the most recent redirect.
REQ-027 The block SHALL ignore mem_ready in IDLE and HOLD.

Reset
REQ-028 When rst=1, the block SHALL immediately, without waiting for clk, set state=IDLE, pc=RESET_ADDR, mem_addr=RESET_ADDR, mem_req=0, inst_valid=0, inst_data=0, and inst_pc=0.
REQ-029 Reset asserted mid-operation SHALL drop any outstanding request and held instruction with no residual output.
REQ-030 After rst deasserts, the first rising edge SHALL enter FETCH, and mem_req SHALL be 1 one cycle after release.

Verification
REQ-031 Reset release, memory 1-cycle latency returning 0x2010_000A at address 0 -> mem_req=1 with mem_addr=0; then inst_valid=1, inst_data=0x2010_000A, inst_pc=0; after inst_ready, next mem_addr=0x4.
REQ-032 Hold inst_ready=0 for 5 cycles while in HOLD -> inst_valid, inst_data and inst_pc unchanged; mem_req=0 throughout.
REQ-033 Fetch of 0x8 outstanding with memory latency 3, redirect to 0x43 in the 1st wait cycle -> state FLUSH; 0x8 data is never presented; next request mem_addr=0x40.
REQ-034 redirect_valid=1 in the same cycle as mem_ready for 0xC, redirect to 0x100 -> inst_valid stays 0; next cycle mem_req=1 with mem_addr=0x100.
REQ-035 Redirect to 0xFFFF_FFFC, word delivered and accepted -> next mem_addr=0x0000_0000.
REQ-036 rst pulsed asynchronously between clock edges while in HOLD -> inst_valid=0 and mem_req=0 before the next edge; first request after release is at RESET_ADDR.
